// File: rtl/float_seq_normalizer.sv
// Multi-cycle mantissa normalizer: scans one GROUP_SIZE slice per clock from the MSB side,
// then left-shifts the mantissa and lowers the exponent (clamped at zero for subnormals).
module float_seq_normalizer #(
  parameter int MANT_WIDTH = 24,
  parameter int EXP_WIDTH  = 8,
  parameter int GROUP_SIZE = 8,
  parameter int LZ_WIDTH   = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [MANT_WIDTH-1:0] in_mant,
  input  logic [EXP_WIDTH-1:0]  in_exp,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [MANT_WIDTH-1:0] out_mant,
  output logic [EXP_WIDTH-1:0]  out_exp,
  output logic [LZ_WIDTH-1:0]   out_lz,
  output logic                  out_zero,
  output logic [1:0]            dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // valid never depends on ready, and a raised out_valid holds with stable data until taken.

  localparam int NUM_GROUPS = (MANT_WIDTH + GROUP_SIZE - 1) / GROUP_SIZE;
  localparam int PAD_W      = NUM_GROUPS * GROUP_SIZE;
  localparam int LAST_W     = MANT_WIDTH - (NUM_GROUPS - 1) * GROUP_SIZE;
  localparam int G_W        = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
  localparam int CW         = (LZ_WIDTH > EXP_WIDTH) ? LZ_WIDTH : EXP_WIDTH;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SCAN  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]            state;
  logic [MANT_WIDTH-1:0] mant_r;
  logic [EXP_WIDTH-1:0]  exp_r;
  logic [G_W-1:0]        g_r;
  logic [LZ_WIDTH-1:0]   lz_r;
  logic                  zero_r;

  logic [PAD_W-1:0]      padded;
  logic [GROUP_SIZE-1:0] grp;
  logic [LZ_WIDTH-1:0]   grp_lz;
  logic [LZ_WIDTH-1:0]   grp_w;
  logic                  last_grp;
  logic [CW-1:0]         lz_c;
  logic [CW-1:0]         exp_c;
  logic [CW-1:0]         sh;

  assign in_ready  = (state == S_IDLE);
  assign dbg_state = state;

  // A short last group is zero-padded on the LSB side so every group is examined MSB-first.
  always_comb begin
    padded = PAD_W'(mant_r) << (PAD_W - MANT_WIDTH);
    grp    = GROUP_SIZE'(padded >> ((PAD_W - GROUP_SIZE) - int'(g_r) * GROUP_SIZE));
  end

  always_comb begin
    grp_lz = LZ_WIDTH'(GROUP_SIZE);
    for (int i = 0; i < GROUP_SIZE; i++) begin
      if (grp[i]) grp_lz = LZ_WIDTH'(GROUP_SIZE - 1 - i);
    end
  end

  always_comb begin
    last_grp = (g_r == G_W'(NUM_GROUPS - 1));
    grp_w    = last_grp ? LZ_WIDTH'(LAST_W) : LZ_WIDTH'(GROUP_SIZE);
  end

  // Shift is clamped to the exponent so the result degrades to a subnormal instead of wrapping.
  always_comb begin
    lz_c  = CW'(lz_r);
    exp_c = CW'(exp_r);
    sh    = (lz_c < exp_c) ? lz_c : exp_c;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      mant_r    <= '0;
      exp_r     <= '0;
      g_r       <= '0;
      lz_r      <= '0;
      zero_r    <= 1'b0;
      out_valid <= 1'b0;
      out_mant  <= '0;
      out_exp   <= '0;
      out_lz    <= '0;
      out_zero  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            mant_r <= in_mant;
            exp_r  <= in_exp;
            g_r    <= '0;
            lz_r   <= '0;
            zero_r <= 1'b0;
            state  <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (grp != '0) begin
            lz_r  <= lz_r + grp_lz;
            state <= S_SHIFT;
          end else begin
            lz_r <= lz_r + grp_w;
            if (last_grp) begin
              zero_r <= 1'b1;
              state  <= S_SHIFT;
            end else begin
              g_r <= g_r + G_W'(1);
            end
          end
        end
        S_SHIFT: begin
          out_valid <= 1'b1;
          out_zero  <= zero_r;
          if (zero_r) begin
            out_mant <= '0;
            out_exp  <= '0;
            out_lz   <= LZ_WIDTH'(MANT_WIDTH);
          end else begin
            out_mant <= mant_r << sh;
            out_exp  <= exp_r - EXP_WIDTH'(sh);
            out_lz   <= lz_r;
          end
          state <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/float_seq_normalizer.md
Name: float_seq_normalizer

Overview:
Multi-cycle mantissa normalizer. It time-multiplexes a single GROUP_SIZE-wide leading-zero count across a wide mantissa, scanning one group per clock from the MSB side. It then left-shifts the mantissa and reduces the exponent by the shift amount. It sits after the matmul accumulator, ahead of rounding/packing, and trades latency for area against a fully parallel LZC.

Parameters:
MANT_WIDTH, 24, mantissa width in bits (≥ GROUP_SIZE).
EXP_WIDTH, 8, unsigned biased exponent width.
GROUP_SIZE, 8, bits examined per SCAN cycle.
LZ_WIDTH, 5, leading-zero count width; must satisfy 2^LZ_WIDTH > MANT_WIDTH.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  reset, asynchronous, active-high.
in_valid  input  1  input operand valid.
in_ready  output  1  block can accept an operand.
in_mant  input  MANT_WIDTH  unnormalized mantissa.
in_exp  input  EXP_WIDTH  biased exponent of in_mant.
out_valid  output  1  result valid; held until accepted.
out_ready  input  1  consumer accepts result.
out_mant  output  MANT_WIDTH  normalized mantissa.
out_exp  output  EXP_WIDTH  adjusted exponent.
out_lz  output  LZ_WIDTH  leading-zero count of the captured in_mant (MANT_WIDTH when zero).
out_zero  output  1  captured mantissa was all zero.

Behaviour:
- Reset: async, active-high. State goes to IDLE. All output registers go to 0: out_valid, out_mant, out_exp, out_lz, out_zero, plus the group index and lz accumulator. in_ready=1 once state is IDLE.
- States are IDLE, SCAN, SHIFT, DONE. in_ready is 1 only in IDLE. out_valid is 1 only in DONE.
- IDLE: on in_valid & in_ready, register in_mant and in_exp, clear group index g and lz accumulator, go to SCAN.
- Group definition: NUM_GROUPS = ceil(MANT_WIDTH / GROUP_SIZE).
  - Group g=0 is the top GROUP_SIZE bits.
  - Any partial group is the lowest bits and is counted as if zero-padded on the LSB side.
- SCAN (one cycle per group):
  - If group g ≠ 0: lz += leading zeros within the group, then go to SHIFT.
  - Else: lz += width of group g.
    - If g == NUM_GROUPS−1: set zero flag and go to SHIFT.
    - Otherwise g++ and stay in SCAN.
- SHIFT (one cycle):
  - shift = min(lz, captured exp). This is the subnormal clamp.
  - out_mant = mant << shift; out_exp = exp − shift (never wraps below 0); out_lz = lz; out_zero = flag.
  - If zero: out_mant=0, out_exp=0, out_lz=MANT_WIDTH.
  - Go to DONE.
- DONE: outputs stable while out_valid=1 and out_ready=0. On out_ready, go to IDLE.
- Latency: with k = number of groups scanned (1..NUM_GROUPS), out_valid rises k+1 clock edges after the accepting edge.
- Throughput: one operation in flight at a time. A new input can be accepted no earlier than the cycle after the output handshake.
- in_mant/in_exp changes while not in IDLE have no effect.
- Reset asserted mid-SCAN/SHIFT/DONE aborts the operation; no partial result is emitted.

Test Plan:
- in_mant=0x800000, in_exp=100 -> out_valid 2 edges after accept; out_mant=0x800000, out_exp=100, out_lz=0, out_zero=0.
- in_mant=0x000123, in_exp=100 -> k=2, out_valid after 3 edges; out_lz=15, out_mant=0x918000, out_exp=85.
- in_mant=0x000000, in_exp=77 -> k=3, out_valid after 4 edges; out_zero=1, out_mant=0, out_exp=0, out_lz=24.
- in_mant=0x000001, in_exp=5 (subnormal clamp) -> out_lz=23, out_mant=0x000020, out_exp=0.
- Backpressure: hold out_ready=0 for 4 cycles in DONE -> outputs and out_valid stable, in_ready=0. out_ready=1 -> IDLE next edge; a new in_valid is accepted the following cycle.
- Assert rst during SCAN of 0x000123 -> all outputs 0 immediately (asynchronous). After release, in_ready=1. A new 0x400000/exp 10 yields out_lz=1, out_mant=0x800000, out_exp=9.
